// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// Module      : operand_fetch_pkg
// Description : Shared widths and the issue-bundle type for operand fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

    localparam int phit_size    = 512;
    localparam int dwidth_RFadd = 4;
    localparam int depth_RF     = 2 ** dwidth_RFadd;
    localparam int dwidth_op    = 4;

    typedef struct packed {
        logic [dwidth_op-1:0]    op;
        logic [dwidth_RFadd-1:0] dst;
        logic                    wr;
        logic [phit_size-1:0]    a;
        logic [phit_size-1:0]    b;
    } issue_t;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_rf_scoreboard.sv
// ============================================================================
// Module      : rf_scoreboard
// Description : One pending-write bit per register; a set wins over a clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_set_en,
    input  logic [dwidth_RFadd-1:0] i_set_addr,
    input  logic                    i_clr_en,
    input  logic [dwidth_RFadd-1:0] i_clr_addr,
    output logic [depth_RF-1:0]     o_pending
);

    logic [depth_RF-1:0] r_pending;
    logic [depth_RF-1:0] w_set_mask;
    logic [depth_RF-1:0] w_clr_mask;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) w_set_mask[i_set_addr] = 1'b1;
        if (i_clr_en) w_clr_mask[i_clr_addr] = 1'b1;
    end

    // The write-back belongs to an older instruction, so a new claim survives it.
    always_ff @(posedge clk) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end

    assign o_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : Reads operands with write-back bypass, stalls on RAW/WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [dwidth_op-1:0]    in_op,
    input  logic [dwidth_RFadd-1:0] in_src1,
    input  logic [dwidth_RFadd-1:0] in_src2,
    input  logic [dwidth_RFadd-1:0] in_dst,
    input  logic                    in_wr,
    output logic [dwidth_RFadd-1:0] rf_rd_addr1,
    output logic [dwidth_RFadd-1:0] rf_rd_addr2,
    input  logic [phit_size-1:0]    rf_d_out1,
    input  logic [phit_size-1:0]    rf_d_out2,
    input  logic                    wb_wen,
    input  logic [dwidth_RFadd-1:0] wb_addr,
    input  logic [phit_size-1:0]    wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [dwidth_op-1:0]    out_op,
    output logic [dwidth_RFadd-1:0] out_dst,
    output logic                    out_wr,
    output logic [phit_size-1:0]    out_a,
    output logic [phit_size-1:0]    out_b,
    output logic [15:0]             stall_cnt
);

    logic [depth_RF-1:0] w_pending;
    logic                w_bypass1;
    logic                w_bypass2;
    logic                w_bypass_dst;
    logic                w_hazard;
    logic                w_accept;
    issue_t              w_issue;

    logic                r_out_valid;
    issue_t              r_issue;
    logic [15:0]         r_stall_cnt;

    assign rf_rd_addr1  = in_src1;
    assign rf_rd_addr2  = in_src2;

    assign w_bypass1    = wb_wen && (wb_addr == in_src1);
    assign w_bypass2    = wb_wen && (wb_addr == in_src2);
    assign w_bypass_dst = wb_wen && (wb_addr == in_dst);

    // A pending source is fine when its value is arriving on the write-back this cycle.
    assign w_hazard = (w_pending[in_src1] && !w_bypass1)
                   || (w_pending[in_src2] && !w_bypass2)
                   || (in_wr && w_pending[in_dst] && !w_bypass_dst);

    assign in_ready = rst_n && (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_issue.op  = in_op;
        w_issue.dst = in_dst;
        w_issue.wr  = in_wr;
        w_issue.a   = w_bypass1 ? wb_data : rf_d_out1;
        w_issue.b   = w_bypass2 ? wb_data : rf_d_out2;
    end

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_accept && in_wr),
        .i_set_addr (in_dst),
        .i_clr_en   (wb_wen),
        .i_clr_addr (wb_addr),
        .o_pending  (w_pending)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_issue     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_issue     <= w_issue;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (in_valid && w_hazard && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign out_valid = r_out_valid;
    assign out_op    = r_issue.op;
    assign out_dst   = r_issue.dst;
    assign out_wr    = r_issue.wr;
    assign out_a     = r_issue.a;
    assign out_b     = r_issue.b;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed self-checking bench for operand_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [dwidth_op-1:0]    in_op;
    logic [dwidth_RFadd-1:0] in_src1, in_src2, in_dst;
    logic                    in_wr;
    logic [dwidth_RFadd-1:0] rf_rd_addr1, rf_rd_addr2;
    logic [phit_size-1:0]    rf_d_out1, rf_d_out2;
    logic                    wb_wen;
    logic [dwidth_RFadd-1:0] wb_addr;
    logic [phit_size-1:0]    wb_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [dwidth_op-1:0]    out_op;
    logic [dwidth_RFadd-1:0] out_dst;
    logic                    out_wr;
    logic [phit_size-1:0]    out_a, out_b;
    logic [15:0]             stall_cnt;

    logic [phit_size-1:0]    rf [depth_RF];
    int                      n_pass;
    int                      n_total;

    assign rf_d_out1 = rf[rf_rd_addr1];
    assign rf_d_out2 = rf[rf_rd_addr2];

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_wr(in_wr),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_d_out1(rf_d_out1), .rf_d_out2(rf_d_out2),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_dst(out_dst), .out_wr(out_wr), .out_a(out_a), .out_b(out_b),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] d, input logic w);
        in_valid = v; in_op = op; in_src1 = s1; in_src2 = s2; in_dst = d; in_wr = w;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b1; wb_wen = 1'b0; wb_addr = '0; wb_data = '0;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step(); step();
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready actual=%0b required=0", in_ready);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0 || dut.w_pending !== 16'h0 || stall_cnt !== 16'd0)
            $display("FAIL reset_state actual v=%0b p=%h s=%0d required v=0 p=0 s=0",
                     out_valid, dut.w_pending, stall_cnt);
        else n_pass++;
        n_total++;
        if (out_a !== '0 || out_b !== '0 || out_op !== 4'd0 || out_dst !== 4'd0 || out_wr !== 1'b0)
            $display("FAIL reset_outputs actual op=%0d dst=%0d wr=%0b required zeros", out_op, out_dst, out_wr);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        drive(1'b1, 4'd3, 4'd2, 4'd5, 4'd7, 1'b1);
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL basic_ready actual=%0b required=1", in_ready);
        else n_pass++;
        n_total++;
        if (rf_rd_addr1 !== 4'd2 || rf_rd_addr2 !== 4'd5)
            $display("FAIL basic_rd_addr actual=%0d,%0d required=2,5", rf_rd_addr1, rf_rd_addr2);
        else n_pass++;
        step();
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_a !== 512'h11 || out_b !== 512'h22)
            $display("FAIL basic_issue actual v=%0b a=%0h b=%0h required v=1 a=11 b=22",
                     out_valid, out_a[31:0], out_b[31:0]);
        else n_pass++;
        n_total++;
        if (out_op !== 4'd3 || out_dst !== 4'd7 || out_wr !== 1'b1 || dut.w_pending !== 16'h0080)
            $display("FAIL basic_fields actual op=%0d dst=%0d wr=%0b p=%h required op=3 dst=7 wr=1 p=0080",
                     out_op, out_dst, out_wr, dut.w_pending);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL basic_drain actual=%0b required=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_hazard;
        drive(1'b1, 4'd1, 4'd7, 4'd0, 4'd1, 1'b0);
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL hazard_ready actual=%0b required=0", in_ready);
        else n_pass++;
        step(); step(); step();
        n_total++;
        if (stall_cnt !== 16'd3 || out_valid !== 1'b0)
            $display("FAIL hazard_stall actual s=%0d v=%0b required s=3 v=0", stall_cnt, out_valid);
        else n_pass++;
        wb_wen = 1'b1; wb_addr = 4'd7; wb_data = 512'hAB;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL hazard_bypass_ready actual=%0b required=1", in_ready);
        else n_pass++;
        step();
        wb_wen = 1'b0; drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_a !== 512'hAB || out_b !== 512'h0 || out_op !== 4'd1)
            $display("FAIL hazard_bypass_issue actual v=%0b a=%0h op=%0d required v=1 a=ab op=1",
                     out_valid, out_a[31:0], out_op);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 16'd3 || dut.w_pending !== 16'h0)
            $display("FAIL hazard_after actual s=%0d p=%h required s=3 p=0000", stall_cnt, dut.w_pending);
        else n_pass++;
        step();
    endtask

    task automatic test_backpressure;
        drive(1'b1, 4'd5, 4'd2, 4'd5, 4'd3, 1'b0);
        step();
        out_ready = 1'b0;
        drive(1'b1, 4'd6, 4'd5, 4'd2, 4'd8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op !== 4'd5 ||
                out_a !== 512'h11 || out_b !== 512'h22 || out_dst !== 4'd3)
                $display("FAIL backpressure_hold cycle=%0d actual rdy=%0b v=%0b op=%0d required rdy=0 v=1 op=5",
                         k, in_ready, out_valid, out_op);
            else n_pass++;
            step();
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL backpressure_release actual=%0b required=1", in_ready);
        else n_pass++;
        step();
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_op !== 4'd6 || out_a !== 512'h22 || out_b !== 512'h11)
            $display("FAIL backpressure_next actual v=%0b op=%0d a=%0h b=%0h required v=1 op=6 a=22 b=11",
                     out_valid, out_op, out_a[31:0], out_b[31:0]);
        else n_pass++;
        step();
    endtask

    task automatic test_set_wins;
        drive(1'b1, 4'd2, 4'd1, 4'd1, 4'd4, 1'b1);
        wb_wen = 1'b1; wb_addr = 4'd4; wb_data = 512'h55;
        step();
        n_total++;
        if (dut.w_pending !== 16'h0010 || out_a !== 512'h33 || out_b !== 512'h33)
            $display("FAIL set_wins actual p=%h a=%0h b=%0h required p=0010 a=33 b=33",
                     dut.w_pending, out_a[31:0], out_b[31:0]);
        else n_pass++;
        drive(1'b1, 4'd9, 4'd4, 4'd4, 4'd0, 1'b0);
        wb_data = 512'h77;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL same_src_ready actual=%0b required=1", in_ready);
        else n_pass++;
        step();
        wb_wen = 1'b0; drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        n_total++;
        if (out_a !== 512'h77 || out_b !== 512'h77 || out_op !== 4'd9 || dut.w_pending !== 16'h0)
            $display("FAIL same_src_bypass actual a=%0h b=%0h op=%0d p=%h required a=77 b=77 op=9 p=0000",
                     out_a[31:0], out_b[31:0], out_op, dut.w_pending);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back;
        logic [phit_size-1:0] ea, eb;
        for (int k = 0; k < depth_RF; k++) rf[k] = 512'h100 + 512'(k);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'(i % 16), 4'(i % 16), 4'((i + 3) % 16), 4'(i % 16), 1'b0);
            #1;
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready i=%0d actual=%0b required=1", i, in_ready);
            else n_pass++;
            step();
            ea = 512'h100 + 512'(i % 16);
            eb = 512'h100 + 512'((i + 3) % 16);
            n_total++;
            if (out_valid !== 1'b1 || out_op !== 4'(i % 16) || out_a !== ea || out_b !== eb)
                $display("FAIL b2b_issue i=%0d actual v=%0b op=%0d a=%0h b=%0h required v=1 op=%0d a=%0h b=%0h",
                         i, out_valid, out_op, out_a[31:0], out_b[31:0], i % 16, ea[31:0], eb[31:0]);
            else n_pass++;
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid;
        for (int d = 4; d < 8; d++) begin
            drive(1'b1, 4'd1, 4'd0, 4'd0, 4'(d), 1'b1);
            step();
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        n_total++;
        if (dut.w_pending !== 16'h00F0 || out_valid !== 1'b1)
            $display("FAIL mid_setup actual p=%h v=%0b required p=00f0 v=1", dut.w_pending, out_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL mid_reset_ready actual=%0b required=0", in_ready);
        else n_pass++;
        step();
        rst_n = 1'b1;
        n_total++;
        if (out_valid !== 1'b0 || dut.w_pending !== 16'h0 || stall_cnt !== 16'd0 || out_a !== '0)
            $display("FAIL mid_reset actual v=%0b p=%h s=%0d required v=0 p=0000 s=0",
                     out_valid, dut.w_pending, stall_cnt);
        else n_pass++;
        drive(1'b1, 4'd2, 4'd7, 4'd4, 4'd7, 1'b1);
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_ready actual=%0b required=1", in_ready);
        else n_pass++;
        step();
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_a !== 512'h107 || out_b !== 512'h104)
            $display("FAIL post_reset_issue actual v=%0b a=%0h b=%0h required v=1 a=107 b=104",
                     out_valid, out_a[31:0], out_b[31:0]);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        for (int k = 0; k < depth_RF; k++) rf[k] = '0;
        rf[1] = 512'h33;
        rf[2] = 512'h11;
        rf[5] = 512'h22;
        test_reset();
        test_basic();
        test_hazard();
        test_backpressure();
        test_set_wins();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 phit_size, 512, operand/data width; shared package.
REQ-002 dwidth_RFadd, 4, register-file address width; shared package.
REQ-003 depth_RF, 16, register count (2**dwidth_RFadd); shared package.
REQ-004 dwidth_op, 4, opcode width; shared package.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 in_valid / in_ready  in / out  1 / 1  instruction handshake.
REQ-008 in_op  in  dwidth_op  opcode; in_src1, in_src2, in_dst  in  dwidth_RFadd  register addresses; in_wr  in  1  instruction writes in_dst.
REQ-009 rf_rd_addr1, rf_rd_addr2  out  dwidth_RFadd  register-file read addresses; rf_d_out1, rf_d_out2  in  phit_size  asynchronous read data.
REQ-010 wb_wen  in  1, wb_addr  in  dwidth_RFadd, wb_data  in  phit_size  copy of the register-file write port (write-back snoop).
REQ-011 out_valid / out_ready  out / in  1 / 1  issue handshake to ALU.
REQ-012 out_op  out  dwidth_op; out_dst  out  dwidth_RFadd; out_wr  out  1; out_a, out_b  out  phit_size  fetched operands.
REQ-013 stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-014 rf_rd_addr1 = in_src1 and rf_rd_addr2 = in_src2, combinationally, every cycle.
REQ-015 Scoreboard: pending[depth_RF-1:0], one bit per register; bit set means a write is outstanding.
REQ-016 bypass1 = wb_wen && wb_addr==in_src1; bypass2 likewise for in_src2.
REQ-017 hazard = (pending[in_src1] && !bypass1) || (pending[in_src2] && !bypass2) || (in_wr && pending[in_dst] && !(wb_wen && wb_addr==in_dst)).
REQ-018 in_ready = (!out_valid || out_ready) && !hazard; in_ready depends on in_valid not at all.
REQ-019 Accept = in_valid && in_ready; on accept, next edge: out_valid=1, out_op/out_dst/out_wr captured, out_a = bypass1 ? wb_data : rf_d_out1, out_b = bypass2 ? wb_data : rf_d_out2.
REQ-020 Latency: accept to out_valid is exactly 1 cycle; back-to-back accepts at 1 per cycle when no hazard and out_ready=1.
REQ-021 out_valid && !out_ready: all out_* held stable; no accept.
REQ-022 out_valid && out_ready && !accept: out_valid clears next edge.
REQ-023 pending[wb_addr] clears on wb_wen; pending[in_dst] sets on accept with in_wr=1.
REQ-024 Simultaneous set and clear of the same bit: set wins (the write-back belongs to the older instruction).
REQ-025 wb_wen to a non-pending register: no scoreboard change, bypass still applied.
REQ-026 src1==src2: both operands take the same value, including under bypass.
REQ-027 stall_cnt increments on each cycle with in_valid && hazard; holds at 16'hFFFF.
REQ-028 Unconnected behaviour: in_valid=0 produces no state change except scoreboard clears from wb_wen.

Reset
REQ-029 On rising clk with rst_n=0: out_valid=0, out_op=0, out_dst=0, out_wr=0, out_a=0, out_b=0, pending=0, stall_cnt=0.
REQ-030 Reset mid-operation discards the held instruction and all pending bits; the first accept is possible in the first cycle with rst_n=1.
REQ-031 in_ready = 0 while rst_n=0.

Structure
REQ-032 phit_size, dwidth_RFadd, depth_RF and dwidth_op, plus a packed issue-bundle typedef (op, dst, wr, a, b), belong in the shared package.
REQ-033 The scoreboard is one sub-module, rf_scoreboard (set/clear ports, pending vector out); the rest is inline.

Verification
REQ-034 Reset, then in: op=3, src1=2, src2=5, dst=7, wr=1, RF[2]=0x11, RF[5]=0x22, out_ready=1 -> next cycle out_valid=1, out_a=0x11, out_b=0x22, pending[7]=1.
REQ-035 With pending[7]=1, in src1=7 with no write-back -> in_ready=0, stall_cnt increments per cycle; wb_wen=1, wb_addr=7, wb_data=0xAB -> accept that cycle, out_a=0xAB.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0; out_ready=1 -> next instruction issues 1 cycle later.
REQ-037 Same cycle: accept with dst=4, wr=1 and wb_wen=1, wb_addr=4 -> pending[4]=1 afterwards.
REQ-038 20 back-to-back independent instructions, out_ready=1 -> 20 consecutive out_valid cycles, in order, operands correct.
REQ-039 rst_n=0 for one cycle while out_valid=1 and pending=0x00F0 -> out_valid=0, pending=0, stall_cnt=0.
